// File: rtl/grf_wb_arbiter_if.sv
// Writeback arbiter bus: requester handshake, GRF write port, scoreboard
// allocation and hazard queries bundled into one interface.
interface grf_wb_arbiter_if #(
    parameter int NREQ = 3,
    parameter int DW   = 32,
    parameter int AW   = 5
);
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ*DW-1:0] req_pc;
    logic               hold;
    logic               grf_we;
    logic [AW-1:0]      grf_a3;
    logic [DW-1:0]      grf_wd;
    logic [DW-1:0]      grf_pc;
    logic               alloc_valid;
    logic [AW-1:0]      alloc_addr;
    logic               alloc_ready;
    logic [AW-1:0]      q_addr1;
    logic [AW-1:0]      q_addr2;
    logic               q_busy1;
    logic               q_busy2;

    // Arbiter side.
    modport slave (
        input  req_valid, req_addr, req_data, req_pc, hold,
        input  alloc_valid, alloc_addr, q_addr1, q_addr2,
        output req_ready, grf_we, grf_a3, grf_wd, grf_pc,
        output alloc_ready, q_busy1, q_busy2
    );

    // Pipeline / requester side.
    modport master (
        output req_valid, req_addr, req_data, req_pc, hold,
        output alloc_valid, alloc_addr, q_addr1, q_addr2,
        input  req_ready, grf_we, grf_a3, grf_wd, grf_pc,
        input  alloc_ready, q_busy1, q_busy2
    );
endinterface

// File: rtl/grf_wb_arbiter.sv
// Round-robin arbiter sharing the single GRF write port among NREQ writeback
// requesters, with a registered write stage and a 2-bit per-register
// pending-write scoreboard for the hazard unit.
// Optional: define GRF_ARB_TRACE_EN to print one trace line per non-$0 write
// as it is loaded into the write stage.
module grf_wb_arbiter #(
    parameter int NREQ = 3,
    parameter int DW   = 32,
    parameter int AW   = 5
) (
    input  logic              clk,
    input  logic              reset,
    grf_wb_arbiter_if.slave   bus
);
    localparam int PW   = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int NREG = 1 << AW;

    logic [PW-1:0] rr_ptr;
    logic [1:0]    pend [NREG];

    logic          gnt;
    logic [PW-1:0] gnt_idx;
    logic [AW-1:0] win_addr;
    logic [DW-1:0] win_data;
    logic [DW-1:0] win_pc;
    logic          alloc_fire;

    // Round-robin search starting at rr_ptr; blocked by hold and by reset.
    always_comb begin
        int idx;
        gnt     = 1'b0;
        gnt_idx = '0;
        idx     = 0;
        if (reset && !bus.hold) begin
            for (int k = 0; k < NREQ; k++) begin
                idx = (int'(rr_ptr) + k) % NREQ;
                if (!gnt && bus.req_valid[idx]) begin
                    gnt     = 1'b1;
                    gnt_idx = PW'(idx);
                end
            end
        end
        bus.req_ready = gnt ? (NREQ'(1) << gnt_idx) : '0;
        win_addr      = bus.req_addr[gnt_idx*AW +: AW];
        win_data      = bus.req_data[gnt_idx*DW +: DW];
        win_pc        = bus.req_pc[gnt_idx*DW +: DW];
    end

    // Scoreboard lookups come only from registered counters, so a same-cycle
    // write never releases an alloc stall or clears a busy flag early.
    always_comb begin
        bus.alloc_ready = (pend[bus.alloc_addr] != 2'd3);
        alloc_fire      = bus.alloc_valid && bus.alloc_ready;
        bus.q_busy1     = (pend[bus.q_addr1] != 2'd0);
        bus.q_busy2     = (pend[bus.q_addr2] != 2'd0);
    end

    // Pointer moves past the winner; idle cycles leave it alone.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_ptr <= '0;
        end else if (gnt) begin
            rr_ptr <= (gnt_idx == PW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end

    // Write stage: a granted $0 write is consumed but never enabled.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus.grf_we <= 1'b0;
            bus.grf_a3 <= '0;
            bus.grf_wd <= '0;
            bus.grf_pc <= '0;
        end else begin
            bus.grf_we <= gnt && (win_addr != '0);
            if (gnt) begin
                bus.grf_a3 <= win_addr;
                bus.grf_wd <= win_data;
                bus.grf_pc <= win_pc;
`ifdef GRF_ARB_TRACE_EN
                if (win_addr != '0)
                    $display("@%h: $%d <= %h", win_pc, win_addr, win_data);
`endif
            end
        end
    end

    // Pending counters: alloc and write on the same register cancel; an
    // unexpected write to an idle register leaves it at zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int r = 0; r < NREG; r++) pend[r] <= 2'd0;
        end else begin
            pend[0] <= 2'd0;
            for (int r = 1; r < NREG; r++) begin
                if ((alloc_fire && bus.alloc_addr == AW'(r)) &&
                    !(gnt && win_addr == AW'(r))) begin
                    pend[r] <= pend[r] + 2'd1;
                end else if ((gnt && win_addr == AW'(r)) &&
                             !(alloc_fire && bus.alloc_addr == AW'(r)) &&
                             pend[r] != 2'd0) begin
                    pend[r] <= pend[r] - 2'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_grf_wb_arbiter.sv
module tb_grf_wb_arbiter;
    logic clk;
    logic reset;
    int   n_cmp;
    int   n_mis;

    grf_wb_arbiter_if #(.NREQ(3), .DW(32), .AW(5)) bus ();

    grf_wb_arbiter #(.NREQ(3), .DW(32), .AW(5)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Requester-side state, packed onto the bus by push().
    logic        rv [3];
    logic [4:0]  ra [3];
    logic [31:0] rd [3];
    logic [31:0] rp [3];

    typedef struct {
        logic [2:0] valid;
        logic       hold;
        logic [2:0] exp_ready;
        logic       exp_we;
        logic [4:0] exp_a3;
    } vec_t;
    vec_t tbl [10];

    // Reference model state.
    int          m_rr;
    int          m_pend [32];
    logic        m_we;
    logic [4:0]  m_a3;
    logic [31:0] m_wd;
    logic [31:0] m_pc;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push();
        for (int i = 0; i < 3; i++) begin
            bus.req_valid[i]         = rv[i];
            bus.req_addr[i*5 +: 5]   = ra[i];
            bus.req_data[i*32 +: 32] = rd[i];
            bus.req_pc[i*32 +: 32]   = rp[i];
        end
    endtask

    task automatic idle();
        for (int i = 0; i < 3; i++) begin
            rv[i] = 1'b0; ra[i] = 5'(i + 1); rd[i] = 32'hA + 32'(i); rp[i] = 32'h1000 + 32'(4 * i);
        end
        push();
        bus.hold        = 1'b0;
        bus.alloc_valid = 1'b0;
        bus.alloc_addr  = '0;
        bus.q_addr1     = '0;
        bus.q_addr2     = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        idle();
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        int g;
        logic [2:0] exp_ready;
        logic       exp_aready;
        logic       a_fire;
        int         last_g;

        n_cmp = 0;
        n_mis = 0;
        reset = 1'b0;
        idle();

        // Reset values while reset is held.
        #1;
        chk("rst_we", 64'(bus.grf_we), 64'd0);
        chk("rst_a3", 64'(bus.grf_a3), 64'd0);
        chk("rst_wd", 64'(bus.grf_wd), 64'd0);
        chk("rst_pc", 64'(bus.grf_pc), 64'd0);
        rv[0] = 1'b1; rv[1] = 1'b1; rv[2] = 1'b1; push();
        #1;
        chk("rst_ready", 64'(bus.req_ready), 64'd0);
        chk("rst_aready", 64'(bus.alloc_ready), 64'd1);

        // Round-robin with all requesters continuously valid.
        do_reset();
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            rv[0] = 1'b1; rv[1] = 1'b1; rv[2] = 1'b1; push();
            #1;
            chk("rr_ready", 64'(bus.req_ready), 64'(3'b001 << (c % 3)));
            @(posedge clk); #1;
            chk("rr_a3", 64'(bus.grf_a3), 64'((c % 3) + 1));
            chk("rr_wd", 64'(bus.grf_wd), 64'(32'hA + 32'(c % 3)));
            chk("rr_we", 64'(bus.grf_we), 64'd1);
        end

        // Table-driven arbitration sequence; rr_ptr is back at 0 here.
        tbl[0] = '{3'b111, 1'b0, 3'b001, 1'b1, 5'd1};
        tbl[1] = '{3'b111, 1'b0, 3'b010, 1'b1, 5'd2};
        tbl[2] = '{3'b101, 1'b0, 3'b100, 1'b1, 5'd3};
        tbl[3] = '{3'b110, 1'b0, 3'b010, 1'b1, 5'd2};
        tbl[4] = '{3'b011, 1'b1, 3'b000, 1'b0, 5'd2};
        tbl[5] = '{3'b011, 1'b0, 3'b001, 1'b1, 5'd1};
        tbl[6] = '{3'b000, 1'b0, 3'b000, 1'b0, 5'd1};
        tbl[7] = '{3'b100, 1'b0, 3'b100, 1'b1, 5'd3};
        tbl[8] = '{3'b010, 1'b0, 3'b010, 1'b1, 5'd2};
        tbl[9] = '{3'b001, 1'b0, 3'b001, 1'b1, 5'd1};
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            for (int j = 0; j < 3; j++) rv[j] = tbl[i].valid[j];
            push();
            bus.hold = tbl[i].hold;
            #1;
            chk("tbl_ready", 64'(bus.req_ready), 64'(tbl[i].exp_ready));
            @(posedge clk); #1;
            chk("tbl_we", 64'(bus.grf_we), 64'(tbl[i].exp_we));
            chk("tbl_a3", 64'(bus.grf_a3), 64'(tbl[i].exp_a3));
        end

        // Hold for 4 cycles with requesters 0 and 2 valid, then release.
        do_reset();
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            rv[0] = 1'b1; rv[1] = 1'b0; rv[2] = 1'b1; push();
            bus.hold = (c < 4);
            #1;
            chk("hold_ready", 64'(bus.req_ready),
                (c < 4) ? 64'd0 : ((c == 4) ? 64'b001 : 64'b100));
            @(posedge clk); #1;
            chk("hold_we", 64'(bus.grf_we), (c < 4) ? 64'd0 : 64'd1);
        end

        // Scoreboard on $5.
        do_reset();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            bus.alloc_valid = 1'b1; bus.alloc_addr = 5'd5;
            #1;
            chk("sb_alloc_ok", 64'(bus.alloc_ready), 64'd1);
        end
        @(negedge clk);
        bus.q_addr1 = 5'd5;
        rv[0] = 1'b1; ra[0] = 5'd5; rd[0] = 32'h55; push();
        #1;
        chk("sb_busy5", 64'(bus.q_busy1), 64'd1);
        chk("sb_full", 64'(bus.alloc_ready), 64'd0);
        chk("sb_wr_ready", 64'(bus.req_ready), 64'b001);
        @(negedge clk);
        #1;
        chk("sb_after_wr", 64'(bus.alloc_ready), 64'd1);
        chk("sb_wr2_ready", 64'(bus.req_ready), 64'b001);
        @(negedge clk);
        rv[0] = 1'b0; push();
        #1;
        chk("sb_after_both", 64'(bus.alloc_ready), 64'd1);
        @(negedge clk);
        bus.alloc_valid = 1'b0; bus.q_addr2 = 5'd6;
        #1;
        chk("sb_full_again", 64'(bus.alloc_ready), 64'd0);
        chk("sb_busy6", 64'(bus.q_busy2), 64'd0);

        // Write to $0: consumed with ready, never enabled.
        do_reset();
        @(negedge clk);
        rv[1] = 1'b1; ra[1] = 5'd0; rd[1] = 32'hDEAD; push();
        #1;
        chk("z_ready", 64'(bus.req_ready), 64'b010);
        @(posedge clk); #1;
        chk("z_we", 64'(bus.grf_we), 64'd0);
        @(negedge clk);
        rv[1] = 1'b0; push();
        #1;
        chk("z_ready_off", 64'(bus.req_ready), 64'd0);

        // Randomised run against the reference model.
        do_reset();
        m_rr = 0;
        for (int r = 0; r < 32; r++) m_pend[r] = 0;
        m_we = 1'b0; m_a3 = '0; m_wd = '0; m_pc = '0;
        for (int i = 0; i < 3; i++) rv[i] = 1'b0;
        last_g = -1;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                if (last_g == i) rv[i] = 1'b0;
                if (!rv[i] && ($urandom_range(1, 0) == 1)) begin
                    rv[i] = 1'b1;
                    ra[i] = 5'($urandom_range(7, 0));
                    rd[i] = $urandom;
                    rp[i] = $urandom;
                end
            end
            push();
            bus.hold        = ($urandom_range(7, 0) == 0);
            bus.alloc_valid = ($urandom_range(1, 0) == 1);
            bus.alloc_addr  = 5'($urandom_range(7, 0));
            bus.q_addr1     = 5'($urandom_range(7, 0));
            bus.q_addr2     = 5'($urandom_range(7, 0));
            #1;
            g = -1;
            if (!bus.hold) begin
                for (int k = 0; k < 3; k++) begin
                    if (g < 0 && rv[(m_rr + k) % 3]) g = (m_rr + k) % 3;
                end
            end
            exp_ready  = (g >= 0) ? 3'(1 << g) : 3'b000;
            exp_aready = (m_pend[bus.alloc_addr] != 3);
            chk("rnd_ready", 64'(bus.req_ready), 64'(exp_ready));
            chk("rnd_aready", 64'(bus.alloc_ready), 64'(exp_aready));
            chk("rnd_busy1", 64'(bus.q_busy1), 64'(m_pend[bus.q_addr1] != 0));
            chk("rnd_busy2", 64'(bus.q_busy2), 64'(m_pend[bus.q_addr2] != 0));
            chk("rnd_we", 64'(bus.grf_we), 64'(m_we));
            chk("rnd_a3", 64'(bus.grf_a3), 64'(m_a3));
            chk("rnd_wd", 64'(bus.grf_wd), 64'(m_wd));
            chk("rnd_pc", 64'(bus.grf_pc), 64'(m_pc));
            a_fire = bus.alloc_valid && exp_aready;
            if (g >= 0) begin
                m_rr = (g + 1) % 3;
                m_we = (ra[g] != 0);
                m_a3 = ra[g]; m_wd = rd[g]; m_pc = rp[g];
            end else begin
                m_we = 1'b0;
            end
            if (a_fire && g >= 0 && bus.alloc_addr == ra[g]) begin
                // alloc and write on the same register cancel
            end else begin
                if (a_fire && bus.alloc_addr != 0) m_pend[bus.alloc_addr]++;
                if (g >= 0 && ra[g] != 0 && m_pend[ra[g]] > 0) m_pend[ra[g]]--;
            end
            last_g = g;
        end

        // Reset asserted mid-stream while a write sits in the output stage.
        @(negedge clk);
        rv[0] = 1'b1; rv[1] = 1'b1; rv[2] = 1'b1;
        ra[0] = 5'd1; ra[1] = 5'd2; ra[2] = 5'd3; push();
        bus.hold = 1'b0; bus.alloc_valid = 1'b1; bus.alloc_addr = 5'd9; bus.q_addr1 = 5'd9;
        @(posedge clk); #1;
        bus.alloc_valid = 1'b0;
        chk("mid_we_before", 64'(bus.grf_we), 64'd1);
        chk("mid_busy9", 64'(bus.q_busy1), 64'd1);
        #1 reset = 1'b0;
        #1;
        chk("mid_we_drop", 64'(bus.grf_we), 64'd0);
        chk("mid_ready", 64'(bus.req_ready), 64'd0);
        chk("mid_aready", 64'(bus.alloc_ready), 64'd1);
        chk("mid_busy9_clr", 64'(bus.q_busy1), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("post_rr0", 64'(bus.req_ready), 64'b001);
        bus.hold = 1'b1;
        for (int r = 0; r < 32; r++) begin
            bus.q_addr1 = 5'(r);
            bus.q_addr2 = 5'(31 - r);
            #1;
            chk("post_busy1", 64'(bus.q_busy1), 64'd0);
            chk("post_busy2", 64'(bus.q_busy2), 64'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule

// File: doc/grf_wb_arbiter.md
# grf_wb_arbiter

Shares the single GRF write port among several writeback requesters, for example ALU, load unit and mult/div unit. Requesters use a valid/ready handshake. The block grants one requester per cycle by round-robin and drives a registered write to the GRF write port. A per-register pending-write scoreboard tells the hazard unit which destination registers still have a write in flight.

## Interface
Parameters:
- `NREQ`, 3: number of writeback requesters (2..4).
- `DW`, 32: data and PC width.
- `AW`, 5: register address width; 32 registers.

Ports:
- `clk`  in  1: single clock, rising edge.
- `reset`  in  1: asynchronous, active-low reset.
- `req_valid`  in  NREQ: requester i has a write pending.
- `req_ready`  out  NREQ: requester i is granted this cycle. The transfer completes on `req_valid[i] && req_ready[i]` at the rising edge.
- `req_addr`  in  NREQ*AW: packed destination addresses; slice i belongs to requester i.
- `req_data`  in  NREQ*DW: packed write data.
- `req_pc`  in  NREQ*DW: packed PC of the producing instruction.
- `hold`  in  1: when 1, no grants are issued.
- `grf_we`  out  1: registered GRF write enable.
- `grf_a3`  out  AW: registered GRF write address.
- `grf_wd`  out  DW: registered GRF write data.
- `grf_pc`  out  DW: registered PC, for the GRF trace.
- `alloc_valid`  in  1: an issued instruction will write `alloc_addr`.
- `alloc_addr`  in  AW: destination register being allocated.
- `alloc_ready`  out  1: the allocation is accepted this cycle.
- `q_addr1`, `q_addr2`  in  AW: scoreboard query addresses.
- `q_busy1`, `q_busy2`  out  1: the queried register has a pending write.

## Operation
- **Arbitration:** combinational round-robin over `req_valid`.
  - Search starts at index `rr_ptr` and wraps modulo NREQ.
  - The first valid index wins. `req_ready` is one-hot or all-zero.
  - When `hold`=1, or no requester is valid, `req_ready` is all zero.
- **Pointer update:** on a grant to index g, `rr_ptr` becomes (g+1) mod NREQ. Without a grant, `rr_ptr` is unchanged.
- **Write stage:** on a grant, the output registers load the winner's addr, data and PC.
  - `grf_we` is 1 only if the granted address is non-zero.
  - A write to $0 is still accepted (ready=1) and consumed, but `grf_we` stays 0.
  - With no grant, `grf_we` is 0 and `grf_a3`, `grf_wd`, `grf_pc` hold their previous values.
- **Scoreboard:** each register 1..31 has a 2-bit pending counter `pend[r]`.
  - Increment on an accepted alloc to r.
  - Decrement on a granted write to r.
  - A simultaneous increment and decrement on the same r leaves the counter unchanged.
  - `pend[0]` is always 0; allocations to $0 are accepted and ignored.
- **Allocation backpressure:** `alloc_ready` = !(`pend[alloc_addr]`==3). At 3 the alloc stalls. A decrement on that register in the same cycle does not release the stall early.
- **Queries:** `q_busy` = (`pend[q_addr]` != 0). Purely combinational from registered state, so it does not reflect a same-cycle alloc or write.
- **Underflow:** a granted write to a register with `pend`==0 is a protocol error. The counter stays 0 and the write proceeds.

## Timing
- **Reset values:**
  - `grf_we`=0, `grf_a3`=0, `grf_wd`=0, `grf_pc`=0.
  - `rr_ptr`=0 and all `pend`=0.
  - `req_ready`=0 and `alloc_ready`=1 while reset is asserted.
- **Reset assertion:** takes effect immediately and asynchronously. Any write in the output stage is dropped, because `grf_we` goes to 0 at once.
- **Write latency:** one cycle. A grant at edge N produces `grf_we`/`grf_a3`/`grf_wd` valid during cycle N+1, committed by the GRF at edge N+1.
- **Busy clear:** `q_busy` for r clears in the cycle after the granting edge. This is the same cycle `grf_we` presents the write, so the hazard unit must also forward from `grf_wd` in that cycle.
- **Throughput:** one write per cycle sustained. With all NREQ requesters continuously valid, each is served once every NREQ cycles.
- **Requester rules:** a requester must hold valid, addr, data and pc stable until ready. `req_ready` may depend combinationally on `req_valid` and `hold`.

## Configuration
- `GRF_ARB_TRACE_EN` defined: on every edge where a write is loaded with a non-zero address, the block calls `$display("@%h: $%d <= %h", pc, addr, data)`.
  - Writes to $0 print nothing.
  - This becomes the single writeback trace point, so the GRF's own display must be disabled.
- Not defined: no `$display`, and the RTL is fully synthesizable with identical port behaviour.

## Test plan
- **Reset:** assert reset mid-stream with `grf_we`=1 → `grf_we` drops to 0 immediately; after release, `rr_ptr`=0 and `q_busy` is 0 for every register.
- **Round-robin:** all three requesters valid continuously, with addrs 1/2/3 and data 0xA/0xB/0xC → `grf_a3` sequence 1,2,3,1,2,3 and each `req_ready` one-hot in turn.
- **Zero register:** requester 1 alone writes $0 with data 0xDEAD → `req_ready[1]`=1 for one cycle and `grf_we` stays 0. With the macro defined, no trace line is printed.
- **Scoreboard:**
  - Three allocs to $5 → `q_busy1`(5)=1; a fourth alloc sees `alloc_ready`=0.
  - A write to $5 → `pend` returns to 2.
  - Alloc and write to $5 in the same cycle → `pend` unchanged.
- **Hold:** hold=1 for 4 cycles with requesters 0 and 2 valid → no grants and `grf_we`=0. On release, requester 0 wins first (`rr_ptr`=0), then requester 2.
- **Trace:** with `GRF_ARB_TRACE_EN`, write 0x12345678 to $8 with pc 0x00003000 → exactly one line `@00003000: $ 8 <= 12345678`.
